// File: rtl/serial_frame_tx.sv
// serial_frame_tx
//   Sends a 5-bit word as an asynchronous frame on one pin:
//   start(0), D0..D4 LSB first, optional even-parity bit, stop(1).
//
//   Build option: define SERIAL_FRAME_TX_PARITY_EN to insert the parity bit
//   (8-bit frame, stop at index 7). Left undefined, the frame is 7 bits and
//   the stop bit is at index 6.
//
//   Parameter CLKS_PER_BIT (1..255): clock cycles per serial bit.
//
//   Ports (user-module slot pinout):
//     io_in[0]    clk, rising edge
//     io_in[1]    reset, synchronous active-high
//     io_in[2]    start, level; 0->1 transition launches a frame
//     io_in[7:3]  data word, D0 = io_in[3]
//     io_out[0]   tx line, idles high
//     io_out[1]   busy
//     io_out[2]   done, one-cycle pulse after the stop bit
//     io_out[5:3] index of the frame bit on tx (0 when idle)
//     io_out[6]   overrun, sticky until reset
//     io_out[7]   bit_strobe, first cycle of each frame bit
module serial_frame_tx #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic [7:0] io_in,
    output logic [7:0] io_out
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef SERIAL_FRAME_TX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

`ifdef SERIAL_FRAME_TX_PARITY_EN
    localparam logic [2:0] STOP_IDX = 3'd7;
`else
    localparam logic [2:0] STOP_IDX = 3'd6;
`endif
    localparam logic [7:0] DIV_LAST = 8'(CLKS_PER_BIT - 1);

    logic       clk, rst, start;
    logic [4:0] data;

    assign clk   = io_in[0];
    assign rst   = io_in[1];
    assign start = io_in[2];
    assign data  = io_in[7:3];

    state_t     state_q, state_d;
    logic [7:0] div_q, div_d;
    logic [2:0] dcnt_q, dcnt_d;
    logic [4:0] shreg_q, shreg_d;
    logic       start_prev_q;
    logic       overrun_q, overrun_d;
`ifdef SERIAL_FRAME_TX_PARITY_EN
    logic       par_q, par_d;
`endif

    logic       tx_q, tx_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic [2:0] idx_q, idx_d;
    logic       strobe_q, strobe_d;

    logic launch, term;

    assign launch = start & ~start_prev_q;
    assign term   = (div_q == DIV_LAST);

    // Next-state logic. Outputs are computed from the next state and then
    // registered, so every pin is a flop and changes on the same edge as the
    // state it describes.
    always_comb begin
        state_d   = state_q;
        div_d     = div_q;
        dcnt_d    = dcnt_q;
        shreg_d   = shreg_q;
        overrun_d = overrun_q;
        done_d    = 1'b0;
`ifdef SERIAL_FRAME_TX_PARITY_EN
        par_d     = par_q;
`endif

        if (state_q == S_IDLE) begin
            div_d = 8'd0;
            if (launch) begin
                state_d = S_START;
                shreg_d = data;
                dcnt_d  = 3'd0;
`ifdef SERIAL_FRAME_TX_PARITY_EN
                par_d   = ^data;
`endif
            end
        end else begin
            // An edge during a frame is flagged and otherwise dropped.
            if (launch) overrun_d = 1'b1;
            div_d = term ? 8'd0 : div_q + 8'd1;
        end

        case (state_q)
            S_IDLE: ;
            S_START: if (term) state_d = S_DATA;
            S_DATA: if (term) begin
                shreg_d = shreg_q >> 1;
                if (dcnt_q == 3'd4) begin
`ifdef SERIAL_FRAME_TX_PARITY_EN
                    state_d = S_PARITY;
`else
                    state_d = S_STOP;
`endif
                end else begin
                    dcnt_d = dcnt_q + 3'd1;
                end
            end
`ifdef SERIAL_FRAME_TX_PARITY_EN
            S_PARITY: if (term) state_d = S_STOP;
`endif
            S_STOP: if (term) begin
                state_d = S_IDLE;
                done_d  = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase

        tx_d  = 1'b1;
        idx_d = 3'd0;
        case (state_d)
            S_START: begin
                tx_d  = 1'b0;
                idx_d = 3'd0;
            end
            S_DATA: begin
                tx_d  = shreg_d[0];
                idx_d = dcnt_d + 3'd1;
            end
`ifdef SERIAL_FRAME_TX_PARITY_EN
            S_PARITY: begin
                tx_d  = par_d;
                idx_d = 3'd6;
            end
`endif
            S_STOP: begin
                tx_d  = 1'b1;
                idx_d = STOP_IDX;
            end
            default: begin
                tx_d  = 1'b1;
                idx_d = 3'd0;
            end
        endcase
        busy_d   = (state_d != S_IDLE);
        strobe_d = busy_d && (div_d == 8'd0);
    end

    always_ff @(posedge clk) begin
        // Tracks the pin even during reset, so a start level held high across
        // reset release is not mistaken for a fresh 0->1 launch edge.
        start_prev_q <= start;
        if (rst) begin
            state_q   <= S_IDLE;
            div_q     <= 8'd0;
            dcnt_q    <= 3'd0;
            shreg_q   <= 5'd0;
            overrun_q <= 1'b0;
`ifdef SERIAL_FRAME_TX_PARITY_EN
            par_q     <= 1'b0;
`endif
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            idx_q     <= 3'd0;
            strobe_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            dcnt_q    <= dcnt_d;
            shreg_q   <= shreg_d;
            overrun_q <= overrun_d;
`ifdef SERIAL_FRAME_TX_PARITY_EN
            par_q     <= par_d;
`endif
            tx_q      <= tx_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            idx_q     <= idx_d;
            strobe_q  <= strobe_d;
        end
    end

    assign io_out = {strobe_q, overrun_q, idx_q, done_q, busy_q, tx_q};

endmodule

// File: tb/tb_serial_frame_tx.sv
module tb_serial_frame_tx;

    localparam int C = 4;
`ifdef SERIAL_FRAME_TX_PARITY_EN
    localparam int F   = 8;
    localparam bit PAR = 1'b1;
`else
    localparam int F   = 7;
    localparam bit PAR = 1'b0;
`endif

    logic       clk = 1'b0, rst = 1'b1, start = 1'b0;
    logic [4:0] data = 5'd0;
    logic [7:0] io_in, io_out;

    assign io_in = {data, start, rst, clk};

    serial_frame_tx #(.CLKS_PER_BIT(C)) dut (
        .io_in (io_in),
        .io_out(io_out)
    );

    always #5 clk = ~clk;

    int checks = 0, failures = 0;

    // Reference model: a frame is a list of F bits; after a launch the line
    // simply shows bit (t-1)/C at cycle t, with t counted from the launch edge.
    bit         m_act = 0, m_done = 0, m_ovr = 0, m_prev = 0;
    int         m_t = 0;
    logic [4:0] m_word = 5'd0;

    function automatic logic frame_bit(logic [4:0] w, int b);
        if (b == 0) return 1'b0;
        if (b <= 5) return w[b-1];
        if (PAR && b == 6) return ^w;
        return 1'b1;
    endfunction

    function automatic logic [7:0] model_out();
        int b;
        b = (m_t - 1) / C;
        if (m_act)
            return {((m_t - 1) % C == 0), m_ovr, 3'(b), 1'b0, 1'b1, frame_bit(m_word, b)};
        return {1'b0, m_ovr, 3'd0, m_done, 1'b0, 1'b1};
    endfunction

    task automatic model_step();
        bit launch, was_busy;
        if (rst) begin
            m_act = 0; m_done = 0; m_ovr = 0; m_t = 0;
        end else begin
            launch   = start && !m_prev;
            was_busy = m_act;
            if (launch && was_busy) m_ovr = 1;
            m_done = 0;
            if (m_act) begin
                m_t++;
                if (m_t == F * C + 1) begin
                    m_act = 0; m_done = 1;
                end
            end
            if (launch && !was_busy) begin
                m_act = 1; m_t = 1; m_word = data; m_done = 0;
            end
        end
        m_prev = start;
    endtask

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // One clock: model and DUT both take the edge; compare 1 time unit later.
    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check("cycle", io_out, model_out());
    endtask

    typedef struct {
        logic [4:0] data;
        logic [7:0] seq_np;  // tx per frame bit, bit k = frame bit k, no parity
        logic [7:0] seq_p;   // same with parity
    } vec_t;

    vec_t tbl[5];

    task automatic run_frame_vs_table(input logic [7:0] seq, input string name);
        for (int k = 0; k < F * C; k++) begin
            check(name, {7'd0, io_out[0]}, {7'd0, seq[k / C]});
            data = 5'($urandom);
            tick();
        end
    endtask

    initial begin
        logic [7:0] seq;
        int guard;

        tbl[0] = '{5'b10110, 8'h6C, 8'hEC};
        tbl[1] = '{5'b00000, 8'h40, 8'h80};
        tbl[2] = '{5'b11111, 8'h7E, 8'hFE};
        tbl[3] = '{5'b00001, 8'h42, 8'hC2};
        tbl[4] = '{5'b10101, 8'h6A, 8'hEA};

        // Reset with start held high, then release without a new edge.
        rst = 1; start = 1;
        repeat (3) tick();
        check("reset_state", io_out, 8'h01);
        rst = 0;
        repeat (5) tick();
        check("no_launch_after_reset", io_out, 8'h01);
        start = 0;
        tick();

        // Table-driven frames.
        foreach (tbl[i]) begin
            seq = PAR ? tbl[i].seq_p : tbl[i].seq_np;
            data = tbl[i].data; start = 1;
            tick();
            start = 0;
            run_frame_vs_table(seq, "table_tx");
            check("table_done", {7'd0, io_out[2]}, 8'd1);
            tick(); tick();
        end

        // Overrun: second edge at cycle 10 of the frame.
        data = 5'b10110; start = 1;
        tick();
        start = 0;
        seq = PAR ? tbl[0].seq_p : tbl[0].seq_np;
        for (int k = 0; k < F * C; k++) begin
            check("ovr_tx", {7'd0, io_out[0]}, {7'd0, seq[k / C]});
            if (k == 9) start = 1;
            tick();
        end
        check("ovr_done", {7'd0, io_out[2]}, 8'd1);
        repeat (F * C) tick();
        check("ovr_sticky_idle", io_out, 8'h41);

        // Back to back: new edge during the done cycle.
        start = 0; tick();
        data = 5'b10101; start = 1;
        tick();
        start = 0;
        repeat (F * C) tick();
        check("b2b_done", {7'd0, io_out[2]}, 8'd1);
        data = 5'b00001; start = 1;
        tick();
        check("b2b_relaunch", {6'd0, io_out[1:0]}, 8'h02);
        start = 0;
        run_frame_vs_table(PAR ? tbl[3].seq_p : tbl[3].seq_np, "b2b_tx");

        // Reset mid-frame at index 3 (overrun is still set from above).
        tick();
        data = 5'b11111; start = 1;
        tick();
        start = 0;
        guard = 0;
        while (io_out[5:3] != 3'd3 && guard < 100) begin
            tick(); guard++;
        end
        check("reach_idx3", {5'd0, io_out[5:3]}, 8'd3);
        rst = 1;
        tick();
        check("mid_reset", io_out, 8'h01);
        rst = 0;
        repeat (F * C + 3) tick();
        check("mid_reset_no_done", io_out, 8'h01);

        // Random traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            rst  = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 9) == 0) start = ~start;
            data = 5'($urandom);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
